// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console controller and its cursor counter.
package text_console_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] CC_CR    = 8'h0D;
    localparam logic [7:0] CC_LF    = 8'h0A;
    localparam logic [7:0] CC_BS    = 8'h08;
    localparam logic [7:0] CC_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] ch;
    } cell_t;

endpackage

// File: rtl/text_console_cursor.sv
// Cursor counter: column, row and row base address with wrap rules; also drives the clear sweep scan.
module text_cursor #(
    parameter int COLS       = 30,
    parameter int ROWS       = 17,
    parameter int ROW_STRIDE = 32,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              home,
    input  logic              advance,
    input  logic              cr,
    input  logic              lf,
    input  logic              bs,
    output logic [4:0]        col,
    output logic [4:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    logic [ADDR_W-1:0] row_base;
    logic              col_end;
    logic              row_end;
    logic              step_row;

    assign col_end  = (col == 5'(COLS - 1));
    assign row_end  = (row == 5'(ROWS - 1));
    assign step_row = lf | (advance & col_end);
    assign at_last  = col_end & row_end;
    assign addr     = row_base + ADDR_W'(col);

    // row_base tracks row*ROW_STRIDE incrementally so no multiplier is needed
    always_ff @(posedge clk) begin
        if (rst || home) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            if (advance) begin
                col <= col_end ? 5'd0 : col + 5'd1;
            end else if (cr) begin
                col <= '0;
            end else if (bs && col != 5'd0) begin
                col <= col - 5'd1;
            end

            if (step_row) begin
                if (row_end) begin
                    row      <= '0;
                    row_base <= '0;
                end else begin
                    row      <= row + 5'd1;
                    row_base <= row_base + ADDR_W'(ROW_STRIDE);
                end
            end
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream to text_ram writer with cursor tracking and a clear sweep.
// Optional TEXT_CONSOLE_CLEAR_ON_RESET_EN: blank the screen after every reset.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int         COLS       = 30,
    parameter int         ROWS       = 17,
    parameter int         ROW_STRIDE = 32,
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] BLANK_ATTR = 8'h07
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [7:0]        in_attr,
    input  logic              clear_req,
    output logic              busy,
    output logic [4:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [15:0]       ram_din
);

    state_t            state;
    state_t            next_state;
    logic              xfer;
    logic              enter_clear;
    logic              issue_write;
    cell_t             wr_cell;
    logic              adv;
    logic              do_cr;
    logic              do_lf;
    logic              do_bs;
    logic [ADDR_W-1:0] cur_addr;
    logic              at_last;
    logic              clear_pend;
    logic              sweep_tail;

    text_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ROW_STRIDE (ROW_STRIDE),
        .ADDR_W     (ADDR_W)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .home    (enter_clear),
        .advance (adv),
        .cr      (do_cr),
        .lf      (do_lf),
        .bs      (do_bs),
        .col     (cur_col),
        .row     (cur_row),
        .addr    (cur_addr),
        .at_last (at_last)
    );

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    // Armed by reset so the first cycle after release starts a sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            clear_pend <= 1'b1;
        end else if (enter_clear) begin
            clear_pend <= 1'b0;
        end
    end
`else
    assign clear_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        xfer        = 1'b0;
        enter_clear = 1'b0;
        issue_write = 1'b0;
        wr_cell     = '0;
        adv         = 1'b0;
        do_cr       = 1'b0;
        do_lf       = 1'b0;
        do_bs       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~clear_req & ~clear_pend;
                xfer     = in_valid & in_ready;
                if (clear_req || clear_pend || (xfer && in_data == CC_FF)) begin
                    next_state  = CLEAR;
                    enter_clear = 1'b1;
                end else if (xfer) begin
                    case (in_data)
                        CC_CR:   do_cr = 1'b1;
                        CC_LF:   do_lf = 1'b1;
                        CC_BS:   do_bs = 1'b1;
                        default: begin
                            adv         = 1'b1;
                            issue_write = 1'b1;
                            wr_cell     = '{attr: in_attr, ch: in_data};
                        end
                    endcase
                end
            end
            CLEAR: begin
                adv         = 1'b1;
                issue_write = 1'b1;
                wr_cell     = '{attr: BLANK_ATTR, ch: CH_SPACE};
                if (at_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Keeps busy high through the cycle that presents the final blank write
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_tail <= 1'b0;
        end else begin
            sweep_tail <= (state == CLEAR) & at_last;
        end
    end

    assign busy = (state == CLEAR) | sweep_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce  <= 1'b0;
            ram_ad  <= '0;
            ram_din <= '0;
        end else begin
            ram_ce <= issue_write;
            if (issue_write) begin
                ram_ad  <= cur_addr;
                ram_din <= wr_cell;
            end
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: vector table, directed corner sequences, random stream vs model.
module tb_text_console_ctrl;

    localparam int COLS   = 30;
    localparam int ROWS   = 17;
    localparam int STRIDE = 32;
    localparam int ADDR_W = 10;
    localparam int CELLS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic [7:0]        in_attr;
    logic              clear_req;
    logic              busy;
    logic [4:0]        cur_col;
    logic [4:0]        cur_row;
    logic              ram_ce;
    logic [ADDR_W-1:0] ram_ad;
    logic [15:0]       ram_din;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference model state
    int m_col, m_row, m_k;
    bit m_clear, m_last, m_pend;
    bit exp_ce;
    int exp_ad, exp_din;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] a;
        logic       c;
        logic       ce;
        logic [9:0] ad;
        logic [15:0] din;
        logic [4:0] col;
        logic [4:0] row;
    } vec_t;

    vec_t tbl[9];

    text_console_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_attr   (in_attr),
        .clear_req (clear_req),
        .busy      (busy),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .ram_ce    (ram_ce),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict with the model, compare registered outputs after the edge
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [7:0] a, input logic c);
        bit exp_ready;
        in_valid  = v;
        in_data   = d;
        in_attr   = a;
        clear_req = c;
        #1;
        exp_ready = !m_clear && !c && !m_pend;
        checkOutput("in_ready", in_ready, exp_ready);
        m_last = 0;
        exp_ce = 0;
        if (m_clear) begin
            exp_ce  = 1;
            exp_ad  = (m_k / COLS) * STRIDE + (m_k % COLS);
            exp_din = 16'h0720;
            m_k++;
            if (m_k == CELLS) begin
                m_clear = 0;
                m_last  = 1;
            end
        end else if (c || m_pend || (v && d == 8'h0C)) begin
            m_clear = 1;
            m_pend  = 0;
            m_k     = 0;
            m_col   = 0;
            m_row   = 0;
        end else if (v) begin
            if (d == 8'h0D) m_col = 0;
            else if (d == 8'h0A) m_row = (m_row + 1) % ROWS;
            else if (d == 8'h08) begin
                if (m_col > 0) m_col--;
            end else begin
                exp_ce  = 1;
                exp_ad  = m_row * STRIDE + m_col;
                exp_din = {a, d};
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row = (m_row + 1) % ROWS;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("ram_ce", ram_ce, exp_ce);
        if (exp_ce) begin
            checkOutput("ram_ad", ram_ad, exp_ad);
            checkOutput("ram_din", ram_din, exp_din);
        end
        if (m_clear) checkOutput("busy_sweep", busy, 1);
        else if (!m_last) checkOutput("busy_idle", busy, 0);
        if (!m_clear) begin
            checkOutput("cur_col", cur_col, m_col);
            checkOutput("cur_row", cur_row, m_row);
        end
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_attr   = 8'h00;
        clear_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_ram_ce", ram_ce, 0);
        checkOutput("rst_ram_ad", ram_ad, 0);
        checkOutput("rst_ram_din", ram_din, 0);
        checkOutput("rst_cur_col", cur_col, 0);
        checkOutput("rst_cur_row", cur_row, 0);
        checkOutput("rst_busy", busy, 0);
        rst     = 1'b0;
        m_col   = 0;
        m_row   = 0;
        m_k     = 0;
        m_clear = 0;
        m_last  = 0;
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
        m_pend  = 1;
`else
        m_pend  = 0;
`endif
    endtask

    task automatic drain(output int writes);
        writes = 0;
        for (int i = 0; i < 600 && (m_clear || m_pend || m_last); i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            if (ram_ce) writes++;
        end
        if (m_clear || m_pend) checkOutput("drain_timeout", 1, 0);
    endtask

    initial begin
        int writes, last_ad, bad_col, guard;
        logic [7:0] d;

        tbl[0] = '{1'b1, 8'h41, 8'h0F, 1'b0, 1'b1, 10'd0,  16'h0F41, 5'd1, 5'd0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 10'd0,  16'h0000, 5'd1, 5'd0};
        tbl[2] = '{1'b1, 8'h0D, 8'h00, 1'b0, 1'b0, 10'd0,  16'h0000, 5'd0, 5'd0};
        tbl[3] = '{1'b1, 8'h08, 8'h00, 1'b0, 1'b0, 10'd0,  16'h0000, 5'd0, 5'd0};
        tbl[4] = '{1'b1, 8'h0A, 8'h00, 1'b0, 1'b0, 10'd0,  16'h0000, 5'd0, 5'd1};
        tbl[5] = '{1'b1, 8'h62, 8'h1E, 1'b0, 1'b1, 10'd32, 16'h1E62, 5'd1, 5'd1};
        tbl[6] = '{1'b1, 8'h63, 8'h2F, 1'b0, 1'b1, 10'd33, 16'h2F63, 5'd2, 5'd1};
        tbl[7] = '{1'b1, 8'h08, 8'h00, 1'b0, 1'b0, 10'd0,  16'h0000, 5'd1, 5'd1};
        tbl[8] = '{1'b1, 8'h64, 8'h07, 1'b0, 1'b1, 10'd33, 16'h0764, 5'd2, 5'd1};

        resetDut();
        drain(writes);
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
        checkOutput("reset_sweep_writes", writes, CELLS);
`endif

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].c);
            checkOutput("tbl_ce", ram_ce, tbl[i].ce);
            if (tbl[i].ce) begin
                checkOutput("tbl_ad", ram_ad, tbl[i].ad);
                checkOutput("tbl_din", ram_din, tbl[i].din);
            end
            checkOutput("tbl_col", cur_col, tbl[i].col);
            checkOutput("tbl_row", cur_row, tbl[i].row);
        end

        // Line wrap at the last column
        applyStimulus(1'b1, 8'h0D, 8'h00, 1'b0);
        for (int i = 0; i < 20 && m_row != 0; i++) applyStimulus(1'b1, 8'h0A, 8'h00, 1'b0);
        for (int i = 0; i < 29; i++) applyStimulus(1'b1, 8'h78, 8'h03, 1'b0);
        checkOutput("pre_wrap_col", cur_col, 29);
        checkOutput("pre_wrap_row", cur_row, 0);
        applyStimulus(1'b1, 8'h5A, 8'h07, 1'b0);
        checkOutput("wrap_ad", ram_ad, 29);
        checkOutput("wrap_din", ram_din, 16'h075A);
        checkOutput("wrap_col", cur_col, 0);
        checkOutput("wrap_row", cur_row, 1);
        applyStimulus(1'b1, 8'h71, 8'h07, 1'b0);
        checkOutput("next_row_ad", ram_ad, 32);

        // LF wrap from the bottom row, CR, BS at column 0
        applyStimulus(1'b1, 8'h0D, 8'h00, 1'b0);
        for (int i = 0; i < 20 && m_row != 16; i++) applyStimulus(1'b1, 8'h0A, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h2E, 8'h07, 1'b0);
        checkOutput("pos_5_16", {cur_row, cur_col}, {5'd16, 5'd5});
        applyStimulus(1'b1, 8'h0A, 8'h00, 1'b0);
        checkOutput("lf_wrap_ce", ram_ce, 0);
        checkOutput("lf_wrap", {cur_row, cur_col}, {5'd0, 5'd5});
        applyStimulus(1'b1, 8'h0D, 8'h00, 1'b0);
        checkOutput("cr_ce", ram_ce, 0);
        checkOutput("cr_home", {cur_row, cur_col}, 0);
        applyStimulus(1'b1, 8'h08, 8'h00, 1'b0);
        checkOutput("bs_at_0", {cur_row, cur_col}, 0);

        // Full clear sweep
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        writes = 0; last_ad = 0; bad_col = 0;
        for (int i = 0; i < 600 && m_clear; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            if (ram_ce) begin
                writes++;
                last_ad = ram_ad;
                if (ram_ad[4:0] >= 5'd30) bad_col++;
            end
        end
        checkOutput("sweep_writes", writes, CELLS);
        checkOutput("sweep_last_ad", last_ad, 541);
        checkOutput("sweep_bad_col", bad_col, 0);
        checkOutput("sweep_home", {cur_row, cur_col}, 0);

        // clear_req beats a simultaneous char; char waits for the sweep
        applyStimulus(1'b1, 8'h4B, 8'h0F, 1'b1);
        checkOutput("clr_vs_char_ce", ram_ce, 0);
        for (int i = 0; i < 600 && m_clear; i++) applyStimulus(1'b1, 8'h4B, 8'h0F, 1'b0);
        applyStimulus(1'b1, 8'h4B, 8'h0F, 1'b0);
        checkOutput("pending_char_ce", ram_ce, 1);
        checkOutput("pending_char_ad", ram_ad, 0);
        checkOutput("pending_char_din", ram_din, 16'h0F4B);

        // Reset mid-sweep
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        guard = 0;
        while (m_k < 100 && guard < 200) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            guard++;
        end
        resetDut();
        drain(writes);
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
        checkOutput("post_rst_sweep_writes", writes, CELLS);
`else
        checkOutput("post_rst_no_sweep", writes, 0);
`endif

        // Random byte stream against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 19))
                0, 1:    d = 8'h0D;
                2, 3:    d = 8'h0A;
                4, 5:    d = 8'h08;
                6:       d = ($urandom_range(0, 9) == 0) ? 8'h0C : 8'h41;
                default: d = 8'($urandom_range(8'h20, 8'h7E));
            endcase
            applyStimulus(1'($urandom_range(0, 3) != 0), d, 8'($urandom),
                          1'($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
